// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package data_mem_responder_pkg;

    localparam int unsigned DATA_BUS = 32;

    // Access size encoding; value 3 is reserved and always treated as misaligned.
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } MEM_SIZE;

    // Responder FSM state encoding.
    typedef logic [1:0] MEM_RESP_STATE;
    localparam MEM_RESP_STATE IDLE = 2'd0;
    localparam MEM_RESP_STATE BUSY = 2'd1;
    localparam MEM_RESP_STATE DONE = 2'd2;

    // Misaligned: half on an odd byte, word off a word boundary, or reserved size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic w_mis;
        unique case (size)
            MEM_BYTE: w_mis = 1'b0;
            MEM_HALF: w_mis = offset[0];
            MEM_WORD: w_mis = (offset != 2'b00);
            default:  w_mis = 1'b1;
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Combinational byte-lane steering for the data-memory responder: store byte-enables and
// replicated write word, load lane extraction with sign/zero extension, misalign flag.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]          i_offset,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [DATA_BUS-1:0] i_wdata,
    input  logic [DATA_BUS-1:0] i_rword,
    output logic [3:0]          o_be,
    output logic [DATA_BUS-1:0] o_wword,
    output logic [DATA_BUS-1:0] o_rdata,
    output logic                o_misalign
);

    logic [DATA_BUS-1:0] w_lane;
    logic [15:0]         w_half;

    // Steer lanes by size and offset; a misaligned access enables nothing and reads zero.
    always_comb begin
        o_misalign = is_misaligned(i_size, i_offset);
        o_be       = 4'b0000;
        o_wword    = '0;
        o_rdata    = '0;
        w_lane     = i_rword >> {i_offset, 3'b000};
        w_half     = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
        case (i_size)
            MEM_BYTE: begin
                o_be    = 4'b0001 << i_offset;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'b0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
            end
            MEM_HALF: begin
                o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
                o_wword = {2{i_wdata[15:0]}};
                o_rdata = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            MEM_WORD: begin
                o_be    = 4'b1111;
                o_wword = i_wdata;
                o_rdata = i_rword;
            end
            default: ;
        endcase
        if (o_misalign) begin
            o_be    = 4'b0000;
            o_rdata = '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: one load/store per request, fixed LATENCY busy cycles,
// stall while outstanding, one-cycle completion pulse with extended read data.
// Optional feature macro: MEM_RESP_PERF_EN adds completed load/store counters.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ReqValidM_i,
    input  logic                ReqWriteM_i,
    input  logic [DATA_BUS-1:0] AddrM_i,
    input  logic [DATA_BUS-1:0] WriteDataM_i,
    input  logic [1:0]          SizeM_i,
    input  logic                UnsignedM_i,
    output logic                StallM_o,
    output logic [DATA_BUS-1:0] ReadDataM_o,
    output logic                RespValidM_o,
    output logic                MisalignM_o
`ifdef MEM_RESP_PERF_EN
    ,
    output logic [31:0]         LoadCountM_o,
    output logic [31:0]         StoreCountM_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    MEM_RESP_STATE       r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_write;
    logic [AW+1:0]       r_addr;
    logic [DATA_BUS-1:0] r_wdata;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [DATA_BUS-1:0] r_rdata;
    logic                r_misalign;
    logic [DATA_BUS-1:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0]       w_idx;
    logic                w_fire;
    logic [3:0]          w_be;
    logic [DATA_BUS-1:0] w_wword;
    logic [DATA_BUS-1:0] w_rdata_ext;
    logic                w_misalign;
    logic                w_addr_unused;

    // Upper address bits are intentionally dropped so the array wraps.
    assign w_addr_unused = ^AddrM_i[DATA_BUS-1:AW+2];
    assign w_idx         = r_addr[AW+1:2];
    assign w_fire        = (r_state == BUSY) && (r_cnt == '0);

    mem_lane_align u_lane_align (
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rword    (r_mem[w_idx]),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_rdata_ext),
        .o_misalign (w_misalign)
    );

    // FSM, latency counter, request latch and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ReqValidM_i) begin
                        r_write    <= ReqWriteM_i;
                        r_addr     <= AddrM_i[AW+1:0];
                        r_wdata    <= WriteDataM_i;
                        r_size     <= SizeM_i;
                        r_unsigned <= UnsignedM_i;
                        r_cnt      <= CNT_INIT;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_rdata    <= r_write ? '0 : w_rdata_ext;
                        r_misalign <= w_misalign;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_rdata    <= '0;
                    r_misalign <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Array write on the completing edge; reset on the same edge suppresses it.
    always_ff @(posedge clk) begin
        if (rst_n && w_fire && r_write && !w_misalign) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

    // Stall follows the request combinationally in IDLE and holds through BUSY.
    always_comb begin
        StallM_o     = (r_state == IDLE) ? ReqValidM_i : (r_state == BUSY);
        RespValidM_o = (r_state == DONE);
        MisalignM_o  = r_misalign;
        ReadDataM_o  = r_rdata;
    end

`ifdef MEM_RESP_PERF_EN
    logic [31:0] r_load_cnt;
    logic [31:0] r_store_cnt;

    // Count completed aligned accesses in their DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else if ((r_state == DONE) && !r_misalign) begin
            if (r_write) r_store_cnt <= r_store_cnt + 32'd1;
            else         r_load_cnt  <= r_load_cnt + 32'd1;
        end
    end

    assign LoadCountM_o  = r_load_cnt;
    assign StoreCountM_o = r_store_cnt;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus random accesses against
// a byte-array reference model. Covers the MEM_RESP_PERF_EN counters when that macro is set.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 2;
    localparam int unsigned NBYTE = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ReqValidM_i = 1'b0;
    logic        ReqWriteM_i = 1'b0;
    logic [31:0] AddrM_i = '0;
    logic [31:0] WriteDataM_i = '0;
    logic [1:0]  SizeM_i = 2'd0;
    logic        UnsignedM_i = 1'b0;
    logic        StallM_o;
    logic [31:0] ReadDataM_o;
    logic        RespValidM_o;
    logic        MisalignM_o;
`ifdef MEM_RESP_PERF_EN
    logic [31:0] LoadCountM_o;
    logic [31:0] StoreCountM_o;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] mbytes [NBYTE];
    int unsigned ld_cnt = 0;
    int unsigned st_cnt = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ReqValidM_i  (ReqValidM_i),
        .ReqWriteM_i  (ReqWriteM_i),
        .AddrM_i      (AddrM_i),
        .WriteDataM_i (WriteDataM_i),
        .SizeM_i      (SizeM_i),
        .UnsignedM_i  (UnsignedM_i),
        .StallM_o     (StallM_o),
        .ReadDataM_o  (ReadDataM_o),
        .RespValidM_o (RespValidM_o),
        .MisalignM_o  (MisalignM_o)
`ifdef MEM_RESP_PERF_EN
        ,
        .LoadCountM_o  (LoadCountM_o),
        .StoreCountM_o (StoreCountM_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array, accesses computed from size/offset arithmetic.
    task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         output logic [31:0] exp_rd, output logic exp_mis);
        int base;
        int n;
        logic [31:0] val;
        base = int'(addr) % NBYTE;
        n    = (size == 2'd3) ? 4 : (1 << size);
        exp_mis = (size == 2'd3) || (base % n != 0);
        exp_rd  = '0;
        if (!exp_mis) begin
            if (wr) begin
                for (int b = 0; b < n; b++) mbytes[base + b] = 8'(wdata >> (8 * b));
                st_cnt++;
            end else begin
                val = '0;
                for (int b = 0; b < n; b++) val = val | (32'(mbytes[base + b]) << (8 * b));
                if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
                exp_rd = val;
                ld_cnt++;
            end
        end
    endtask

    // Issue one access from an IDLE cycle and check it cycle by cycle; ends in the next IDLE.
    task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        logic [31:0] exp_rd;
        logic        exp_mis;
        model(wr, addr, wdata, size, uns, exp_rd, exp_mis);
        ReqValidM_i  = 1'b1;
        ReqWriteM_i  = wr;
        AddrM_i      = addr;
        WriteDataM_i = wdata;
        SizeM_i      = size;
        UnsignedM_i  = uns;
        for (int c = 0; c <= int'(LAT); c++) begin
            @(negedge clk);
            check({tag, " stall"}, 32'(StallM_o), 32'd1);
            check({tag, " resp_early"}, 32'(RespValidM_o), 32'd0);
            @(posedge clk);
            #1;
            if (c == 0) begin
                // Latched copy must be used from here on.
                ReqValidM_i  = 1'b0;
                ReqWriteM_i  = 1'($urandom);
                AddrM_i      = $urandom;
                WriteDataM_i = $urandom;
                SizeM_i      = 2'($urandom);
                UnsignedM_i  = 1'($urandom);
            end
        end
        @(negedge clk);
        check({tag, " stall_done"}, 32'(StallM_o), 32'd0);
        check({tag, " resp"}, 32'(RespValidM_o), 32'd1);
        check({tag, " misalign"}, 32'(MisalignM_o), 32'(exp_mis));
        if (!wr || exp_mis) check({tag, " rdata"}, ReadDataM_o, exp_rd);
        @(posedge clk);
        #1;
        check({tag, " resp_clear"}, 32'(RespValidM_o), 32'd0);
`ifdef MEM_RESP_PERF_EN
        check({tag, " ldcnt"}, LoadCountM_o, ld_cnt);
        check({tag, " stcnt"}, StoreCountM_o, st_cnt);
`endif
    endtask

    task automatic check_idle_zero(input string tag);
        @(negedge clk);
        check({tag, " stall"}, 32'(StallM_o), 32'd0);
        check({tag, " resp"}, 32'(RespValidM_o), 32'd0);
        check({tag, " misalign"}, 32'(MisalignM_o), 32'd0);
        check({tag, " rdata"}, ReadDataM_o, 32'd0);
`ifdef MEM_RESP_PERF_EN
        check({tag, " ldcnt"}, LoadCountM_o, 32'd0);
        check({tag, " stcnt"}, StoreCountM_o, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero the whole array so every later load has a defined model value.
        for (int i = 0; i < int'(DEPTH); i++) access("init", 1'b1, 32'(4 * i), 32'd0, 2'd2, 1'b0);

        access("st_word", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0);
        access("ld_word", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        access("st_byte", 1'b1, 32'h21, 32'h80, 2'd0, 1'b0);
        access("ld_byte_s", 1'b0, 32'h21, 32'h0, 2'd0, 1'b0);
        access("ld_byte_u", 1'b0, 32'h21, 32'h0, 2'd0, 1'b1);
        access("ld_w20", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        access("ld_half_mis", 1'b0, 32'h13, 32'h0, 2'd1, 1'b0);
        access("st_word_mis", 1'b1, 32'h22, 32'hFFFF_FFFF, 2'd2, 1'b0);
        access("ld_w20_again", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        access("ld_w10_again", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        access("rsvd_size", 1'b0, 32'h10, 32'h0, 2'd3, 1'b0);
        access("st_wrap", 1'b1, 32'h40, 32'h1234, 2'd2, 1'b0);
        access("ld_wrap", 1'b0, 32'h00, 32'h0, 2'd2, 1'b0);
        access("ld_half_hi", 1'b0, 32'h12, 32'h0, 2'd1, 1'b0);

        // Reset during the second BUSY cycle of a store abandons it.
        ReqValidM_i  = 1'b1;
        ReqWriteM_i  = 1'b1;
        AddrM_i      = 32'h8;
        WriteDataM_i = 32'hA5A5_A5A5;
        SizeM_i      = 2'd2;
        @(posedge clk);
        #1;
        ReqValidM_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        ld_cnt = 0;
        st_cnt = 0;
        check_idle_zero("rst_busy");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access("ld_after_rst", 1'b0, 32'h8, 32'h0, 2'd2, 1'b0);

`ifdef MEM_RESP_PERF_EN
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        ld_cnt = 0;
        st_cnt = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access("perf_l1", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        access("perf_l2", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        access("perf_s1", 1'b1, 32'h30, 32'h55, 2'd2, 1'b0);
        access("perf_l3", 1'b0, 32'h24, 32'h0, 2'd1, 1'b0);
        access("perf_s2", 1'b1, 32'h31, 32'h66, 2'd0, 1'b0);
        access("perf_mis", 1'b0, 32'h13, 32'h0, 2'd1, 1'b0);
        check("perf_loads", LoadCountM_o, 32'd3);
        check("perf_stores", StoreCountM_o, 32'd2);
`endif

        // Random mix of sizes, offsets and wrapping addresses.
        for (int i = 0; i < 60; i++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                // Mostly aligned so the array contents keep changing.
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            access("rand", 1'($urandom), a, $urandom, sz, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
